// File: rtl/serial_adder_fsm.sv
// Bit-serial adder: one full-adder cell walks A + B + carry_in LSB-first, one bit per clock.
// The sum and carry_out outputs are registered and only change when an operation completes.
module serial_adder_fsm #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             carry_in_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_out_o
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, res_q, sum_q;
  logic [CntW-1:0]  cnt_q;
  logic             carry_q, cout_q, busy_q, done_q;
  logic             bit_s, bit_c;

  // Single full-adder cell on the operand LSBs and the registered carry.
  assign bit_s = a_q[0] ^ b_q[0] ^ carry_q;
  assign bit_c = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            a_q     <= a_i;
            b_q     <= b_i;
            carry_q <= carry_in_i;
            res_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          carry_q <= bit_c;
          res_q   <= {bit_s, res_q[WIDTH-1:1]};
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == CntW'(WIDTH - 1)) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          sum_q   <= res_q;
          cout_q  <= carry_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign sum_o       = sum_q;
  assign carry_out_o = cout_q;

endmodule

// File: tb/tb_serial_adder_fsm.sv
// Directed and randomized checks of serial_adder_fsm (WIDTH=8 and WIDTH=2 instances) against
// plain integer addition.
module tb_serial_adder_fsm;

  logic       clk;
  logic       rst_n;
  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       start2, cin2, busy2, done2, cout2;
  logic [1:0] a2, b2, sum2;

  int checks = 0;
  int errors = 0;
  int both   = 0;

  serial_adder_fsm #(.WIDTH(8)) dut8 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start8), .a_i(a8), .b_i(b8), .carry_in_i(cin8),
    .busy_o(busy8), .done_o(done8), .sum_o(sum8), .carry_out_o(cout8)
  );

  serial_adder_fsm #(.WIDTH(2)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start2), .a_i(a2), .b_i(b2), .carry_in_i(cin2),
    .busy_o(busy2), .done_o(done2), .sum_o(sum2), .carry_out_o(cout2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a start for one edge; returns just after the accepting edge.
  task automatic start_op8(input logic [7:0] a, input logic [7:0] b, input logic c);
    @(negedge clk);
    start8 = 1'b1; a8 = a; b8 = b; cin8 = c;
    step();
    start8 = 1'b0;
    a8 = ~a; b8 = ~b; cin8 = ~c;
  endtask

  // Counts edges after the accepting edge until done; bounded.
  task automatic wait_done8(output int lat, output int bcnt);
    lat  = 0;
    bcnt = busy8 ? 1 : 0;
    while (done8 !== 1'b1 && lat < 40) begin
      step();
      lat++;
      if (busy8 === 1'b1) bcnt++;
      if (busy8 === 1'b1 && done8 === 1'b1) both++;
    end
  endtask

  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic c);
    int       lat, bcnt;
    logic [8:0] exp;
    exp = {1'b0, a} + {1'b0, b} + {8'd0, c};
    start_op8(a, b, c);
    wait_done8(lat, bcnt);
    check({tag, "_lat"}, 64'(lat), 64'd9);
    check({tag, "_res"}, {55'd0, cout8, sum8}, {55'd0, exp});
  endtask

  initial begin
    int         lat, bcnt, ndone;
    logic [7:0] ra, rb;
    logic       rc;

    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
    repeat (3) step();
    check("rst_busy", 64'(busy8), 64'd0);
    check("rst_done", 64'(done8), 64'd0);
    check("rst_res", {55'd0, cout8, sum8}, 64'd0);
    check("rst_w2", {59'd0, busy2, done2, cout2, sum2}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Zero operands: latency and busy width.
    start_op8(8'h00, 8'h00, 1'b0);
    wait_done8(lat, bcnt);
    check("zero_lat", 64'(lat), 64'd9);
    check("zero_busy_cycles", 64'(bcnt), 64'd9);
    check("zero_busy_at_done", 64'(busy8), 64'd0);
    check("zero_res", {55'd0, cout8, sum8}, 64'd0);
    step();
    check("zero_done_pulse", 64'(done8), 64'd0);

    op8("ff_01", 8'hFF, 8'h01, 1'b0);
    op8("7f_01", 8'h7F, 8'h01, 1'b0);
    op8("a5_5a", 8'hA5, 8'h5A, 1'b1);

    for (int i = 0; i < 200; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      op8("rand", ra, rb, rc);
    end
    check("busy_done_overlap", 64'(both), 64'd0);

    // Start during RUN is ignored; start during the done cycle is accepted.
    start_op8(8'h12, 8'h34, 1'b0);
    lat = 0;
    ndone = 0;
    while (done8 !== 1'b1 && lat < 40) begin
      step();
      lat++;
      if (lat == 2) begin
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
      end else begin
        start8 = 1'b0;
      end
    end
    start8 = 1'b0;
    check("ign_lat", 64'(lat), 64'd9);
    check("ign_res", {55'd0, cout8, sum8}, 64'h046);
    start8 = 1'b1; a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0;
    step();
    start8 = 1'b0; a8 = 8'hEE; b8 = 8'hEE;
    check("b2b_single_done", 64'(done8), 64'd0);
    check("b2b_accept_busy", 64'(busy8), 64'd1);
    check("b2b_hold_sum", 64'(sum8), 64'h46);
    wait_done8(lat, bcnt);
    check("b2b_lat", 64'(lat), 64'd9);
    check("b2b_res", {55'd0, cout8, sum8}, 64'h003);

    // Reset in mid-operation aborts with no done.
    start_op8(8'hF0, 8'h0F, 1'b0);
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy8), 64'd0);
    check("abort_res", {55'd0, cout8, sum8}, 64'd0);
    check("abort_done", 64'(done8), 64'd0);
    repeat (2) step();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done8 === 1'b1 || busy8 === 1'b1) ndone++;
    end
    check("abort_no_done", 64'(ndone), 64'd0);
    op8("after_rst", 8'h10, 8'h20, 1'b0);

    // WIDTH=2 instance.
    @(negedge clk);
    start2 = 1'b1; a2 = 2'b11; b2 = 2'b11; cin2 = 1'b1;
    step();
    start2 = 1'b0; a2 = 2'b00; b2 = 2'b00; cin2 = 1'b0;
    lat = 0;
    while (done2 !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    check("w2_lat", 64'(lat), 64'd3);
    check("w2_res", {61'd0, cout2, sum2}, 64'h7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
